// File: rtl/multicycle_alu_sequencer_if.sv
// Instruction handshake, memory handshake and datapath control strobes of the
// multicycle ALU sequencer. Instruction fetch and memory stimulus use the master modport.
interface multicycle_alu_sequencer_if #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALU_CTR_W = 3
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [OPCODE_W-1:0]  opcode;
  logic [FUNCT_W-1:0]   funct;
  logic                 mem_ready;
  logic [ALU_CTR_W-1:0] alu_ctr;
  logic                 alu_src;
  logic                 reg_write;
  logic                 mem_read;
  logic                 mem_write;
  logic                 byte_op;
  logic                 branch;
  logic                 done;
  logic                 illegal;
  logic                 timeout;

  modport master (
    output instr_valid, opcode, funct, mem_ready,
    input  instr_ready, alu_ctr, alu_src, reg_write, mem_read, mem_write,
           byte_op, branch, done, illegal, timeout
  );

  modport slave (
    input  instr_valid, opcode, funct, mem_ready,
    output instr_ready, alu_ctr, alu_src, reg_write, mem_read, mem_write,
           byte_op, branch, done, illegal, timeout
  );
endinterface

// File: rtl/multicycle_alu_sequencer.sv
// Multicycle ALU control sequencer: IDLE -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional MEM wait limit is enabled by defining MEM_TIMEOUT_EN.
module multicycle_alu_sequencer #(
  parameter int OPCODE_W       = 6,
  parameter int FUNCT_W        = 6,
  parameter int ALU_CTR_W      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_alu_sequencer_if.slave   bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000101);
  localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000110);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_LB   = OPCODE_W'(6'b001010);
  localparam logic [OPCODE_W-1:0] OP_SB   = OPCODE_W'(6'b001011);

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b000011);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b000100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b000101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b000111);

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_AND = 3'b100;
  localparam logic [2:0] ALUOP_OR  = 3'b101;
  localparam logic [2:0] ALUOP_SLT = 3'b110;
  localparam logic [2:0] ALUOP_R   = 3'b111;

  localparam logic [2:0] CTR_AND = 3'b000;
  localparam logic [2:0] CTR_OR  = 3'b001;
  localparam logic [2:0] CTR_ADD = 3'b010;
  localparam logic [2:0] CTR_SUB = 3'b110;
  localparam logic [2:0] CTR_SLT = 3'b111;

  typedef enum logic [1:0] {K_ALU, K_BRANCH, K_LOAD, K_STORE} kind_e;

  logic [2:0]          state_q,  state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [FUNCT_W-1:0]  funct_q,  funct_d;

  logic       op_legal, fn_legal, legal;
  logic [2:0] aluop;
  logic [2:0] ctr3;
  kind_e      kind;
  logic       imm_src;
  logic       is_byte;
  logic       mem_expired;

  // Opcode decode of the captured instruction.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    op_legal = 1'b1;
    aluop    = ALUOP_ADD;
    kind     = K_ALU;
    imm_src  = 1'b1;
    is_byte  = 1'b0;
    case (opcode_q)
      OP_R:    begin aluop = ALUOP_R; imm_src = 1'b0; end
      OP_ADDI: aluop = ALUOP_ADD;
      OP_ANDI: aluop = ALUOP_AND;
      OP_ORI:  aluop = ALUOP_OR;
      OP_SLTI: aluop = ALUOP_SLT;
      OP_BEQ, OP_BNE: begin
        aluop   = ALUOP_SUB;
        kind    = K_BRANCH;
        imm_src = 1'b0;
      end
      OP_LW:   kind = K_LOAD;
      OP_SW:   kind = K_STORE;
      OP_LB:   begin kind = K_LOAD;  is_byte = 1'b1; end
      OP_SB:   begin kind = K_STORE; is_byte = 1'b1; end
      default: op_legal = 1'b0;
    endcase
  end

  // ALUop to alu_ctr; funct is consulted only for R-type.
  always_comb begin
    fn_legal = 1'b1;
    ctr3     = CTR_ADD;
    case (aluop)
      ALUOP_ADD: ctr3 = CTR_ADD;
      ALUOP_SUB: ctr3 = CTR_SUB;
      ALUOP_AND: ctr3 = CTR_AND;
      ALUOP_OR:  ctr3 = CTR_OR;
      ALUOP_SLT: ctr3 = CTR_SLT;
      ALUOP_R: begin
        case (funct_q)
          FN_ADD:  ctr3 = CTR_ADD;
          FN_SUB:  ctr3 = CTR_SUB;
          FN_AND:  ctr3 = CTR_AND;
          FN_OR:   ctr3 = CTR_OR;
          FN_SLT:  ctr3 = CTR_SLT;
          default: fn_legal = 1'b0;
        endcase
      end
      default: fn_legal = 1'b0;
    endcase
  end

  assign legal = op_legal & fn_legal;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign mem_expired = (state_q == ST_MEM) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign cnt_d       = (state_q == ST_MEM && state_d == ST_MEM) ? cnt_q + 1'b1 : '0;
  assign bus.timeout = mem_expired & ~bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign mem_expired = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          opcode_d = bus.opcode;
          funct_d  = bus.funct;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: state_d = legal ? ST_EXEC : ST_IDLE;
      ST_EXEC: begin
        case (kind)
          K_BRANCH:        state_d = ST_IDLE;
          K_LOAD, K_STORE: state_d = ST_MEM;
          default:         state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready)  state_d = (kind == K_LOAD) ? ST_WB : ST_IDLE;
        else if (mem_expired) state_d = ST_IDLE;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: reset clears all state, including the captured instruction, so no X reaches the decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  logic in_exec, in_mem, in_wb, alu_phase;

  assign in_exec   = (state_q == ST_EXEC);
  assign in_mem    = (state_q == ST_MEM);
  assign in_wb     = (state_q == ST_WB);
  assign alu_phase = in_exec | in_mem;

  assign bus.instr_ready = (state_q == ST_IDLE);
  assign bus.alu_ctr     = alu_phase ? ALU_CTR_W'(ctr3) : '0;
  assign bus.alu_src     = alu_phase & imm_src;
  assign bus.reg_write   = in_wb;
  assign bus.mem_read    = in_mem & (kind == K_LOAD);
  assign bus.mem_write   = in_mem & (kind == K_STORE);
  assign bus.byte_op     = (in_mem | in_wb) & is_byte;
  assign bus.branch      = in_exec & (kind == K_BRANCH);
  assign bus.illegal     = (state_q == ST_DECODE) & ~legal;
  // A store finishes in the same cycle memory accepts it, so done follows mem_ready there.
  assign bus.done        = in_wb
                         | (in_exec & (kind == K_BRANCH))
                         | (in_mem & (kind == K_STORE) & bus.mem_ready);

endmodule

// File: tb/tb_multicycle_alu_sequencer.sv
// Self-checking bench for multicycle_alu_sequencer: directed table, reset abort and
// randomized instruction stream against an instruction-level reference model.
module tb_multicycle_alu_sequencer;

  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum {K_ALU, K_BR, K_LD, K_ST} kind_e;

  typedef struct packed {
    logic       instr_ready;
    logic [2:0] alu_ctr;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       byte_op;
    logic       branch;
    logic       done;
    logic       illegal;
    logic       timeout;
  } outs_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    bit         legal;
    logic [2:0] ctr;
    bit         src;
    kind_e      kind;
    bit         bytef;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  outs_t exp_q[$];
  vec_t  vecs[$];
  outs_t idle_o;

  always #5 clk = ~clk;

  multicycle_alu_sequencer_if #(.OPCODE_W(6), .FUNCT_W(6), .ALU_CTR_W(3)) bus ();

  multicycle_alu_sequencer #(
    .OPCODE_W(6), .FUNCT_W(6), .ALU_CTR_W(3), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic outs_t sample();
    outs_t o;
    o.instr_ready = bus.instr_ready;
    o.alu_ctr     = bus.alu_ctr;
    o.alu_src     = bus.alu_src;
    o.reg_write   = bus.reg_write;
    o.mem_read    = bus.mem_read;
    o.mem_write   = bus.mem_write;
    o.byte_op     = bus.byte_op;
    o.branch      = bus.branch;
    o.done        = bus.done;
    o.illegal     = bus.illegal;
    o.timeout     = bus.timeout;
    return o;
  endfunction

  task automatic check(input string name, input outs_t act, input outs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b expected %b (rdy,ctr,src,rw,mr,mw,byte,br,done,ill,to)",
               name, $time, act, exp);
    end
  endtask

  // Reference model: instruction semantics straight from the opcode/funct tables.
  function automatic void ref_decode(input logic [5:0] op, input logic [5:0] fn,
                                     output bit legal, output logic [2:0] ctr,
                                     output bit src, output kind_e kind, output bit bytef);
    legal = 1; ctr = 3'b010; src = 1; kind = K_ALU; bytef = 0;
    case (op)
      6'd0: begin
        src = 0;
        case (fn)
          6'd2: ctr = 3'b010;
          6'd3: ctr = 3'b110;
          6'd4: ctr = 3'b000;
          6'd5: ctr = 3'b001;
          6'd7: ctr = 3'b111;
          default: legal = 0;
        endcase
      end
      6'd1: ctr = 3'b010;
      6'd2: ctr = 3'b000;
      6'd3: ctr = 3'b001;
      6'd4: ctr = 3'b111;
      6'd5, 6'd6: begin ctr = 3'b110; src = 0; kind = K_BR; end
      6'd8:  kind = K_LD;
      6'd9:  kind = K_ST;
      6'd10: begin kind = K_LD; bytef = 1; end
      6'd11: begin kind = K_ST; bytef = 1; end
      default: legal = 0;
    endcase
  endfunction

  // Expected per-cycle outputs from the DECODE cycle up to the last busy cycle.
  function automatic void build_seq(input bit legal, input logic [2:0] ctr, input bit src,
                                    input kind_e kind, input bit bytef, input int k);
    outs_t o, m;
    int    n;
    bit    expired;
    exp_q.delete();
    o = '0;
    if (!legal) begin
      o.illegal = 1'b1;
      exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    o.alu_ctr = ctr;
    o.alu_src = src;
    case (kind)
      K_ALU: begin
        exp_q.push_back(o);
        m = '0; m.reg_write = 1'b1; m.done = 1'b1;
        exp_q.push_back(m);
      end
      K_BR: begin
        o.branch = 1'b1; o.done = 1'b1;
        exp_q.push_back(o);
      end
      default: begin
        exp_q.push_back(o);
        expired = TO_EN && (k > TO);
        n = expired ? TO : k;
        for (int i = 1; i <= n; i++) begin
          m = o;
          m.mem_read  = (kind == K_LD);
          m.mem_write = (kind == K_ST);
          m.byte_op   = bytef;
          if (i == n) begin
            if (expired)           m.timeout = 1'b1;
            else if (kind == K_ST) m.done    = 1'b1;
          end
          exp_q.push_back(m);
        end
        if (kind == K_LD && !expired) begin
          m = '0; m.reg_write = 1'b1; m.done = 1'b1; m.byte_op = bytef;
          exp_q.push_back(m);
        end
      end
    endcase
  endfunction

  // Called at a negedge with the DUT expected idle; returns at the next idle negedge.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int k, input bit is_mem, input bit noise);
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.funct       = fn;
    bus.mem_ready   = 1'($urandom_range(0, 1));
    #1;
    check({name, ".idle"}, sample(), idle_o);
    @(posedge clk);
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(negedge clk);
      bus.instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        bus.opcode = 6'($urandom);
        bus.funct  = 6'($urandom);
      end
      if (is_mem && c >= 3 && c < 2 + k) bus.mem_ready = 1'b0;
      else if (is_mem && c == 2 + k)     bus.mem_ready = 1'b1;
      else                               bus.mem_ready = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("%s.c%0d", name, c), sample(), exp_q[c-1]);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input int k, input bit legal, input logic [2:0] ctr, input bit src,
                         input kind_e kind, input bit bytef);
    vec_t v;
    v.name = name; v.op = op; v.fn = fn; v.k = k; v.legal = legal;
    v.ctr = ctr; v.src = src; v.kind = kind; v.bytef = bytef;
    vecs.push_back(v);
  endtask

  initial begin
    bit         r_legal, r_src, r_byte;
    logic [2:0] r_ctr;
    kind_e      r_kind;
    logic [5:0] op, fn;
    int         k;
    outs_t      o;

    idle_o = '0;
    idle_o.instr_ready = 1'b1;

    add_vec("r_add",   6'h00, 6'h02, 1, 1, 3'b010, 0, K_ALU, 0);
    add_vec("r_sub",   6'h00, 6'h03, 1, 1, 3'b110, 0, K_ALU, 0);
    add_vec("r_and",   6'h00, 6'h04, 1, 1, 3'b000, 0, K_ALU, 0);
    add_vec("r_or",    6'h00, 6'h05, 1, 1, 3'b001, 0, K_ALU, 0);
    add_vec("r_slt",   6'h00, 6'h07, 1, 1, 3'b111, 0, K_ALU, 0);
    add_vec("r_fn0",   6'h00, 6'h00, 1, 0, 3'b000, 0, K_ALU, 0);
    add_vec("r_fn6",   6'h00, 6'h06, 1, 0, 3'b000, 0, K_ALU, 0);
    add_vec("addi",    6'h01, 6'h15, 1, 1, 3'b010, 1, K_ALU, 0);
    add_vec("andi",    6'h02, 6'h00, 1, 1, 3'b000, 1, K_ALU, 0);
    add_vec("ori",     6'h03, 6'h3f, 1, 1, 3'b001, 1, K_ALU, 0);
    add_vec("slti",    6'h04, 6'h02, 1, 1, 3'b111, 1, K_ALU, 0);
    add_vec("beq",     6'h05, 6'h02, 1, 1, 3'b110, 0, K_BR,  0);
    add_vec("bne",     6'h06, 6'h00, 1, 1, 3'b110, 0, K_BR,  0);
    add_vec("lw_k1",   6'h08, 6'h00, 1, 1, 3'b010, 1, K_LD,  0);
    add_vec("lw_k4",   6'h08, 6'h00, 4, 1, 3'b010, 1, K_LD,  0);
    add_vec("lw_k5",   6'h08, 6'h00, 5, 1, 3'b010, 1, K_LD,  0);
    add_vec("sw_k2",   6'h09, 6'h00, 2, 1, 3'b010, 1, K_ST,  0);
    add_vec("lb_k3",   6'h0a, 6'h00, 3, 1, 3'b010, 1, K_LD,  1);
    add_vec("sb_k1",   6'h0b, 6'h00, 1, 1, 3'b010, 1, K_ST,  1);
    add_vec("sw_k6",   6'h09, 6'h00, 6, 1, 3'b010, 1, K_ST,  0);
    add_vec("ill_3f",  6'h3f, 6'h02, 1, 0, 3'b000, 0, K_ALU, 0);
    add_vec("ill_07",  6'h07, 6'h02, 1, 0, 3'b000, 0, K_ALU, 0);
    add_vec("ill_0c",  6'h0c, 6'h02, 1, 0, 3'b000, 0, K_ALU, 0);

    // Reset, with a request pending that must not be taken while reset is high.
    reset           = 1'b1;
    bus.instr_valid = 1'b1;
    bus.opcode      = 6'h00;
    bus.funct       = 6'h02;
    bus.mem_ready   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hold", sample(), idle_o);
    bus.instr_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("reset_release", sample(), idle_o);
    @(negedge clk);

    // Directed table, back to back.
    for (int i = 0; i < vecs.size(); i++) begin
      build_seq(vecs[i].legal, vecs[i].ctr, vecs[i].src, vecs[i].kind, vecs[i].bytef, vecs[i].k);
      run_instr(vecs[i].name, vecs[i].op, vecs[i].fn, vecs[i].k,
                vecs[i].kind == K_LD || vecs[i].kind == K_ST, 1'b0);
    end

    // Store stalled in MEM, reset in the 2nd MEM cycle abandons it.
    bus.instr_valid = 1'b1;
    bus.opcode      = 6'h09;
    bus.funct       = 6'h00;
    bus.mem_ready   = 1'b0;
    #1;
    check("rst_sw.idle", sample(), idle_o);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    o = '0; o.alu_ctr = 3'b010; o.alu_src = 1'b1; o.mem_write = 1'b1;
    check("rst_sw.mem1", sample(), o);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_sw.mem2", sample(), o);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_sw.after", sample(), idle_o);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_sw.quiet%0d", i), sample(), idle_o);
    end
    @(negedge clk);

    // Randomized stream against the reference model.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else                           op = 6'($urandom_range(0, 12));
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
      else                           fn = 6'($urandom_range(0, 8));
      k = $urandom_range(1, 6);
      ref_decode(op, fn, r_legal, r_ctr, r_src, r_kind, r_byte);
      build_seq(r_legal, r_ctr, r_src, r_kind, r_byte, k);
      run_instr($sformatf("rnd%0d_op%02h_fn%02h_k%0d", n, op, fn, k), op, fn, k,
                r_legal && (r_kind == K_LD || r_kind == K_ST), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
